// File: rtl/rst_seq.sv
// ============================================================================
// Module   : rst_seq
// Brief    : Staged per-domain reset sequencer with async assert / sync release
// Revision : 1.0
// ============================================================================
`default_nettype none

module rst_seq #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 4,
  parameter int NUM_DOMAINS = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sw_rst_req,
  input  logic                   ext_hold,
  output logic [NUM_DOMAINS-1:0] rst_n_out,
  output logic                   rst_done,
  output logic [1:0]             rst_cause
);

  localparam int HCNT_W = $clog2(HOLD_CYCLES + 1);
  localparam int GCNT_W = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
  localparam int IDX_W  = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [HCNT_W-1:0] HOLD_LAST = HCNT_W'(HOLD_CYCLES);
  localparam logic [GCNT_W-1:0] GAP_LAST  = GCNT_W'(STAGE_GAP - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'((NUM_DOMAINS > 1) ? NUM_DOMAINS - 2 : 0);

  localparam logic [1:0] CAUSE_EXT = 2'b01;
  localparam logic [1:0] CAUSE_SW  = 2'b10;

  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_RELEASE = 2'd1,
    S_RUN     = 2'd2
  } state_e;

  state_e                 state_q,     state_d;
  logic [HCNT_W-1:0]      hold_cnt_q,  hold_cnt_d;
  logic [GCNT_W-1:0]      gap_cnt_q,   gap_cnt_d;
  logic [IDX_W-1:0]       stage_idx_q, stage_idx_d;
  logic [NUM_DOMAINS-1:0] rst_n_out_q, rst_n_out_d;
  logic                   rst_done_q,  rst_done_d;
  logic [1:0]             rst_cause_q, rst_cause_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_ok;

  // Deassertion synchronizer: a constant 1 ripples in once rst_n is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sync_ok = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_HOLD;
      hold_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      stage_idx_q <= '0;
      rst_n_out_q <= '0;
      rst_done_q  <= 1'b0;
      rst_cause_q <= CAUSE_EXT;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      stage_idx_q <= stage_idx_d;
      rst_n_out_q <= rst_n_out_d;
      rst_done_q  <= rst_done_d;
      rst_cause_q <= rst_cause_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    stage_idx_d = stage_idx_q;
    rst_n_out_d = rst_n_out_q;
    rst_done_d  = rst_done_q;
    rst_cause_d = rst_cause_q;

    case (state_q)
      S_HOLD: begin
        rst_n_out_d = '0;
        rst_done_d  = 1'b0;
        if (sw_rst_req) begin
          hold_cnt_d = '0;
        end else if (sync_ok && !ext_hold) begin
          if (hold_cnt_q == HOLD_LAST) begin
            hold_cnt_d  = '0;
            gap_cnt_d   = '0;
            stage_idx_d = '0;
            rst_n_out_d = NUM_DOMAINS'(1);
            if (NUM_DOMAINS == 1) begin
              state_d    = S_RUN;
              rst_done_d = 1'b1;
            end else begin
              state_d = S_RELEASE;
            end
          end else begin
            hold_cnt_d = hold_cnt_q + HCNT_W'(1);
          end
        end
      end

      S_RELEASE: begin
        // A software request wins over a release due on the same edge.
        if (sw_rst_req) begin
          state_d     = S_HOLD;
          hold_cnt_d  = '0;
          rst_n_out_d = '0;
          rst_done_d  = 1'b0;
          rst_cause_d = CAUSE_SW;
        end else if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d   = '0;
          stage_idx_d = stage_idx_q + IDX_W'(1);
          rst_n_out_d = (rst_n_out_q << 1) | NUM_DOMAINS'(1);
          if (stage_idx_q == IDX_LAST) begin
            state_d    = S_RUN;
            rst_done_d = 1'b1;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + GCNT_W'(1);
        end
      end

      S_RUN: begin
        rst_n_out_d = '1;
        rst_done_d  = 1'b1;
        if (sw_rst_req) begin
          state_d     = S_HOLD;
          hold_cnt_d  = '0;
          rst_n_out_d = '0;
          rst_done_d  = 1'b0;
          rst_cause_d = CAUSE_SW;
        end
      end

      default: begin
        state_d     = S_HOLD;
        hold_cnt_d  = '0;
        rst_n_out_d = '0;
        rst_done_d  = 1'b0;
      end
    endcase
  end

  assign rst_n_out = rst_n_out_q;
  assign rst_done  = rst_done_q;
  assign rst_cause = rst_cause_q;

endmodule

`default_nettype wire

// File: doc/rst_seq.md
Name: rst_seq

Overview:
Reset sequencer that consumes the raw board/testbench reset `rst_n` and produces staged, glitch-free, per-domain resets for the SoC.
- Assertion is asynchronous; deassertion is synchronized to `clk`.
- After deassertion, reset is held for a fixed stretch, then domains are released one at a time in order (domain 0 = interconnect/memory first, last = core).
- Also services a software reset request and an external hold (debug/boot-loader) input.

Parameters:
- SYNC_STAGES, 2, number of flops in the `rst_n` deassertion synchronizer (allowed range 2..4).
- HOLD_CYCLES, 16, cycles reset is held after the synchronized deassertion before domain 0 is released (≥1).
- STAGE_GAP, 4, cycles between release of consecutive domains (≥1).
- NUM_DOMAINS, 3, number of staged reset outputs (≥1).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset; assertion asynchronous, deassertion synchronized internally.
- sw_rst_req  input  1  synchronous single-cycle software reset request.
- ext_hold  input  1  synchronous; while high, the hold counter does not advance.
- rst_n_out  output  NUM_DOMAINS  active-low per-domain resets; bit 0 released first.
- rst_done  output  1  high once every domain is released.
- rst_cause  output  2  cause of last reset: 2'b01 external `rst_n`, 2'b10 software; 2'b00 and 2'b11 unused.

Behaviour:
- Reset is asynchronous and active-low: `rst_n` low immediately clears all state flops, including the synchronizer and `rst_n_out`, with no clock required.
  - Reset values: `rst_n_out` = all 0, `rst_done` = 0, `rst_cause` = 2'b01, state = HOLD, counters = 0.
- Synchronizer: a SYNC_STAGES-deep flop chain clocked by `clk`, async-cleared by `rst_n`, D of first flop tied to 1. Its output `sync_ok` enables the FSM.
- FSM states and transitions:
  - HOLD: all `rst_n_out` = 0, `rst_done` = 0.
    - `hold_cnt` increments each cycle while `sync_ok`=1 and `ext_hold`=0; it holds its value while `ext_hold`=1.
    - When `hold_cnt` reaches HOLD_CYCLES: set `rst_n_out[0]`=1, clear `stage_idx`/`gap_cnt`, go to RELEASE (or to RUN if NUM_DOMAINS=1).
  - RELEASE: `gap_cnt` counts STAGE_GAP cycles, then releases the next bit.
    - `rst_n_out` bits only go 0→1 in index order, and never more than one bit per cycle.
    - On releasing bit NUM_DOMAINS-1, go to RUN; `rst_done` rises on the same edge.
    - `ext_hold` is ignored in RELEASE.
  - RUN: all `rst_n_out` = 1, `rst_done` = 1; stays here until `sw_rst_req` or `rst_n`.
- Timing, with k = first `clk` edge at which `rst_n` is sampled 1 and `ext_hold`=0 throughout:
  - `rst_n_out[0]` rises at edge k+SYNC_STAGES+HOLD_CYCLES.
  - `rst_n_out[i]` rises exactly STAGE_GAP edges after `rst_n_out[i-1]`.
  - `rst_done` rises with the last bit.
  - Defaults: edges k+18, k+22, k+26.
- Software reset: `sw_rst_req`=1 sampled in RELEASE or RUN.
  - Next edge: all `rst_n_out` = 0, `rst_done` = 0, `rst_cause` = 2'b10, `hold_cnt` = 0, state = HOLD.
  - The synchronizer is not cleared, so the release follows HOLD_CYCLES+1 edges later, then staging as above.
  - `sw_rst_req` in HOLD restarts `hold_cnt` at 0.
  - `rst_n` assertion sets `rst_cause` = 2'b01.
- Simultaneous events:
  - `rst_n` low overrides everything.
  - `sw_rst_req` overrides a release scheduled on the same edge; the bit stays 0.
- Reset mid-operation: `rst_n` low in any state returns immediately to the reset values; a `rst_n` glitch shorter than one cycle still fully clears state.
- All outputs are driven directly from flops; there is no combinational path from any input to any output except the async clear.
- `rst_cause` is held across software resets until the next cause event.

Test Plan:
- Power-on with defaults: `rst_n` low 5 cycles, rises before edge k → `rst_n_out` 000 until edge k+18, then 001 at k+18, 011 at k+22, 111 and `rst_done`=1 at k+26, `rst_cause`=01.
- Async assertion: in RUN, drop `rst_n` mid-cycle between edges → `rst_n_out`=000, `rst_done`=0 before next `clk` edge; a 1 ns glitch gives the same result, and the full sequence then restarts.
- Software reset: in RUN, pulse `sw_rst_req` at edge m → `rst_n_out`=000 and `rst_cause`=10 after edge m; bit 0 rises at edge m+17, bit 1 at m+21, bit 2 at m+25.
- External hold: hold `ext_hold`=1 for 10 cycles starting 5 cycles into HOLD → every release edge shifts by exactly 10; `ext_hold` pulsed during RELEASE → no shift.
- Simultaneous: `sw_rst_req` on the edge that would release bit 1 → bit 1 stays 0, all bits cleared, sequence restarts from HOLD.
- Parameter sweep: NUM_DOMAINS=1, STAGE_GAP=1, HOLD_CYCLES=1, SYNC_STAGES=3 → bit 0 and `rst_done` rise together at edge k+4; assertion checks that release order is monotonic and one bit per edge.
